// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: decodes and extends the instruction immediate, then buffers
// {imm, op, illegal} in a DEPTH-entry valid/ready FIFO.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic            in_op_sel,
  input  logic [2:0]      in_op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_op,
  output logic            out_illegal
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_I    = 3'd1;
  localparam logic [2:0] OP_SH   = 3'd2;
  localparam logic [2:0] OP_S    = 3'd3;
  localparam logic [2:0] OP_B    = 3'd4;
  localparam logic [2:0] OP_U    = 3'd5;
  localparam logic [2:0] OP_J    = 3'd6;
  localparam logic [2:0] OP_CSR  = 3'd7;

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [2:0]      auto_op;
  logic [2:0]      dec_op;
  logic [31:0]     v32;
  logic [XLEN-1:0] dec_imm;

  always_comb begin
    opc = in_inst[6:0];
    f3 = in_inst[14:12];
    auto_op = (opc == 7'b0110111 || opc == 7'b0010111) ? OP_U :
              (opc == 7'b1101111) ? OP_J :
              (opc == 7'b1100111 || opc == 7'b0000011) ? OP_I :
              (opc == 7'b0010011) ? ((f3 == 3'b001 || f3 == 3'b101) ? OP_SH : OP_I) :
              (opc == 7'b0100011) ? OP_S :
              (opc == 7'b1100011) ? OP_B :
              (opc == 7'b1110011 && in_inst[14]) ? OP_CSR : OP_NONE;
    dec_op = in_op_sel ? in_op : auto_op;
    v32 = (dec_op == OP_I)   ? {{20{in_inst[31]}}, in_inst[31:20]} :
          (dec_op == OP_SH)  ? ((XLEN == 64) ? {26'b0, in_inst[25:20]} : {27'b0, in_inst[24:20]}) :
          (dec_op == OP_S)   ? {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]} :
          (dec_op == OP_B)   ? {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0} :
          (dec_op == OP_U)   ? {in_inst[31:12], 12'b0} :
          (dec_op == OP_J)   ? {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0} :
          (dec_op == OP_CSR) ? {27'b0, in_inst[19:15]} : 32'b0;
    dec_imm = {XLEN{v32[31]}};
    dec_imm[31:0] = v32;
  end

  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, out_idx;
  logic [CW-1:0]   count_q, count_d;
  logic            in_ready_q, in_ready_d;
  logic            push, pop;
  logic [XLEN-1:0] mem_imm_q [DEPTH];
  logic [XLEN-1:0] mem_imm_d [DEPTH];
  logic [2:0]      mem_op_q  [DEPTH];
  logic [2:0]      mem_op_d  [DEPTH];
  logic            mem_ill_q [DEPTH];
  logic            mem_ill_d [DEPTH];

  assign out_valid   = count_q != '0;
  assign in_ready    = in_ready_q;
  assign out_imm     = mem_imm_q[out_idx];
  assign out_op      = mem_op_q[out_idx];
  assign out_illegal = mem_ill_q[out_idx];

  // When empty the slot just behind rd_ptr is the last entry shown, so the
  // outputs hold; flush re-aims both pointers just past the displayed slot.
  always_comb begin
    push = in_valid & in_ready_q & ~flush;
    pop = out_valid & out_ready;
    out_idx = out_valid ? rd_ptr_q : rd_ptr_q - AW'(1);
    wr_ptr_d = flush ? out_idx + AW'(1) : wr_ptr_q + AW'(push);
    rd_ptr_d = flush ? out_idx + AW'(1) : rd_ptr_q + AW'(pop);
    count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
    in_ready_d = count_d != CW'(DEPTH);
    mem_imm_d = mem_imm_q;
    mem_op_d = mem_op_q;
    mem_ill_d = mem_ill_q;
    if (push) begin
      mem_imm_d[wr_ptr_q] = dec_imm;
      mem_op_d[wr_ptr_q] = dec_op;
      mem_ill_d[wr_ptr_q] = dec_op == OP_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      in_ready_q <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        mem_imm_q[i] <= '0;
        mem_op_q[i] <= '0;
        mem_ill_q[i] <= 1'b0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      in_ready_q <= in_ready_d;
      mem_imm_q <= mem_imm_d;
      mem_op_q <= mem_op_d;
      mem_ill_q <= mem_ill_d;
    end
  end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed vector table, corner sequences and random traffic
// against a queue-based reference model, on XLEN=32 and XLEN=64 instances.
module tb_imm_gen_pipe;
  localparam int DEPTH = 2;

  logic clk = 0;
  logic rst, flush, in_valid, in_op_sel, out_ready;
  logic [31:0] in_inst;
  logic [2:0] in_op;
  logic r32, v32, ill32, r64, v64, ill64;
  logic [2:0] op32, op64;
  logic [31:0] imm32;
  logic [63:0] imm64;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .DEPTH(DEPTH)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r32),
    .in_inst(in_inst), .in_op_sel(in_op_sel), .in_op(in_op), .out_valid(v32),
    .out_ready(out_ready), .out_imm(imm32), .out_op(op32), .out_illegal(ill32));

  imm_gen_pipe #(.XLEN(64), .DEPTH(DEPTH)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r64),
    .in_inst(in_inst), .in_op_sel(in_op_sel), .in_op(in_op), .out_valid(v64),
    .out_ready(out_ready), .out_imm(imm64), .out_op(op64), .out_illegal(ill64));

  typedef struct packed {
    logic [2:0]  op;
    logic        ill;
    logic [31:0] i32;
    logic [63:0] i64;
  } rec_t;

  typedef struct {
    logic [31:0] inst;
    logic        sel;
    logic [2:0]  op;
    logic [31:0] e32;
    logic [63:0] e64;
    logic [2:0]  eop;
    logic        eill;
  } vec_t;

  rec_t q[$];
  rec_t last;
  logic m_ready;
  int total = 0, passed = 0;

  function automatic rec_t mk(logic [31:0] i, logic sel, logic [2:0] xop);
    rec_t r;
    logic [2:0] op;
    logic signed [63:0] s;
    case (i[6:0])
      7'h37, 7'h17: op = 3'd5;
      7'h6F:        op = 3'd6;
      7'h67, 7'h03: op = 3'd1;
      7'h13:        op = (i[14:12] == 3'd1 || i[14:12] == 3'd5) ? 3'd2 : 3'd1;
      7'h23:        op = 3'd3;
      7'h63:        op = 3'd4;
      7'h73:        op = i[14] ? 3'd7 : 3'd0;
      default:      op = 3'd0;
    endcase
    if (sel) op = xop;
    case (op)
      3'd1:    s = $signed(i[31:20]);
      3'd3:    s = $signed({i[31:25], i[11:7]});
      3'd4:    s = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});
      3'd5:    s = $signed({i[31:12], 12'b0});
      3'd6:    s = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0});
      default: s = 64'sd0;
    endcase
    r.op = op;
    r.ill = op == 3'd0;
    r.i64 = s;
    r.i32 = s[31:0];
    if (op == 3'd2) begin
      r.i32 = {27'b0, i[24:20]};
      r.i64 = {58'b0, i[25:20]};
    end
    if (op == 3'd7) begin
      r.i32 = {27'b0, i[19:15]};
      r.i64 = {59'b0, i[19:15]};
    end
    return r;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
  endtask

  task automatic check_model();
    rec_t h;
    chk("in_ready32", 64'(r32), 64'(m_ready));
    chk("in_ready64", 64'(r64), 64'(m_ready));
    chk("valid32", 64'(v32), 64'(q.size() != 0));
    chk("valid64", 64'(v64), 64'(q.size() != 0));
    if (q.size() != 0) last = q[0];
    h = last;
    chk("op32", 64'(op32), 64'(h.op));
    chk("ill32", 64'(ill32), 64'(h.ill));
    chk("imm32", 64'(imm32), 64'(h.i32));
    chk("op64", 64'(op64), 64'(h.op));
    chk("ill64", 64'(ill64), 64'(h.ill));
    chk("imm64", imm64, h.i64);
  endtask

  task automatic step();
    logic push, pop;
    rec_t nr;
    push = in_valid && m_ready && !flush && !rst;
    pop = q.size() != 0 && out_ready && !rst;
    nr = mk(in_inst, in_op_sel, in_op);
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_ready = 1'b1;
      last = '0;
    end else begin
      if (pop) void'(q.pop_front());
      if (flush) q.delete();
      else if (push) q.push_back(nr);
      m_ready = q.size() != DEPTH;
    end
    @(negedge clk);
    check_model();
  endtask

  vec_t vt[12];
  logic [6:0] opcs[10];

  initial begin
    vt[0]  = '{32'hFFF00093, 1'b0, 3'd0, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0};
    vt[1]  = '{32'hFE000EE3, 1'b0, 3'd0, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd4, 1'b0};
    vt[2]  = '{32'h0010006F, 1'b0, 3'd0, 32'h00000800, 64'h0000000000000800, 3'd6, 1'b0};
    vt[3]  = '{32'hFE112C23, 1'b0, 3'd0, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 3'd3, 1'b0};
    vt[4]  = '{32'h02109093, 1'b0, 3'd0, 32'h00000001, 64'd33, 3'd2, 1'b0};
    vt[5]  = '{32'h800000B7, 1'b0, 3'd0, 32'h80000000, 64'hFFFFFFFF80000000, 3'd5, 1'b0};
    vt[6]  = '{32'h0000007F, 1'b0, 3'd0, 32'h0, 64'h0, 3'd0, 1'b1};
    vt[7]  = '{32'hFFF00093, 1'b1, 3'd0, 32'h0, 64'h0, 3'd0, 1'b1};
    vt[8]  = '{32'h000FD073, 1'b0, 3'd0, 32'd31, 64'd31, 3'd7, 1'b0};
    vt[9]  = '{32'h4050D093, 1'b0, 3'd0, 32'd5, 64'd5, 3'd2, 1'b0};
    vt[10] = '{32'h00000073, 1'b0, 3'd0, 32'h0, 64'h0, 3'd0, 1'b1};
    vt[11] = '{32'hFFF00093, 1'b1, 3'd5, 32'hFFF00000, 64'hFFFFFFFFFFF00000, 3'd5, 1'b0};
    opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h23, 7'h63, 7'h73, 7'h33};
    m_ready = 1'b1;
    last = '0;
    rst = 1; flush = 0; in_valid = 0; in_op_sel = 0; in_op = 0; out_ready = 0; in_inst = 0;
    step();
    step();
    chk("rst_imm64", imm64, 64'h0);
    chk("rst_ready32", 64'(r32), 64'h1);
    rst = 0;
    step();
    foreach (vt[k]) begin
      in_valid = 1; out_ready = 0;
      in_inst = vt[k].inst; in_op_sel = vt[k].sel; in_op = vt[k].op;
      step();
      chk($sformatf("vec%0d_valid", k), 64'(v32), 64'h1);
      chk($sformatf("vec%0d_imm32", k), 64'(imm32), 64'(vt[k].e32));
      chk($sformatf("vec%0d_imm64", k), imm64, vt[k].e64);
      chk($sformatf("vec%0d_op", k), 64'(op64), 64'(vt[k].eop));
      chk($sformatf("vec%0d_ill", k), 64'(ill32), 64'(vt[k].eill));
      in_valid = 0; out_ready = 1;
      step();
    end
    in_op_sel = 0; out_ready = 0; in_valid = 1;
    for (int k = 1; k <= 3; k++) begin
      in_inst = {12'(k), 20'h00093};
      step();
      if (k == 2) chk("bp_full_ready", 64'(r32), 64'h0);
    end
    chk("bp_head1", 64'(imm32), 64'd1);
    out_ready = 1;
    step();
    chk("bp_head2", 64'(imm32), 64'd2);
    step();
    chk("bp_head3", 64'(imm32), 64'd3);
    in_valid = 0;
    step();
    chk("bp_empty", 64'(v32), 64'h0);
    out_ready = 0; in_valid = 1;
    in_inst = 32'h00700093; step();
    in_inst = 32'h00800093; step();
    in_inst = 32'h00900093; flush = 1; step();
    chk("flush_valid", 64'(v64), 64'h0);
    chk("flush_ready", 64'(r64), 64'h1);
    flush = 0; in_valid = 0; out_ready = 1;
    step();
    chk("flush_nostale", 64'(v32), 64'h0);
    out_ready = 0; in_valid = 1;
    in_inst = 32'hFFF00093; step();
    in_inst = 32'h800000B7; step();
    rst = 1; in_valid = 0; step();
    chk("rst_mid_valid", 64'(v32), 64'h0);
    chk("rst_mid_imm", imm64, 64'h0);
    chk("rst_mid_op", 64'(op64), 64'h0);
    chk("rst_mid_ready", 64'(r32), 64'h1);
    rst = 0;
    for (int n = 0; n < 600; n++) begin
      in_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      flush = ($urandom % 25) == 0;
      in_inst = $urandom;
      if (($urandom % 4) != 0) in_inst[6:0] = opcs[$urandom_range(0, 9)];
      in_op_sel = ($urandom % 4) == 0;
      in_op = 3'($urandom);
      step();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
